// File: rtl/pcss_link_tx_sched.sv
// -----------------------------------------------------------------------------
// pcss_link_tx_sched
//
// Link transmit scheduler. Config and spike packets of PW bits arrive on two
// request ports. The scheduler serialises the accepted packet into four DW-bit
// flits on the link, MSB flit first, with an even-parity bit per flit. A spike
// is only accepted once its target time step has been reached (or passed).
// Config requests always win over spike requests.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   tik                 time-step toggle; each 1->0 transition advances tik_cnt
//   cfg_valid/data/ready  config packet request port
//   spk_valid/data/ts/ready  spike packet request port with target time step
//   send_data_out/valid/par  link flit, flit valid, XOR parity of the flit
//   send_data_ready/err      link acknowledge and receiver parity-error flag
//   tik_cnt             current time step
//   busy                a packet is in flight (state != IDLE)
//   abort               one-cycle pulse when a packet is dropped after retries
//   err_cnt             saturating count of flits reported bad by the receiver
//   dbg_state           current FSM state (0 IDLE, 1 DRIVE, 2 RELEASE)
//
// Handshakes
//   Request ports: a packet transfers on a rising edge where valid & ready are
//   both high. Ready is a combinational function of valid and is only ever
//   raised in IDLE, for at most one port per cycle.
//   Link side: four-phase. The flit is presented with valid high and held
//   stable until ready is sampled high; valid then drops and the scheduler
//   waits for ready to be sampled low before presenting the next flit. A
//   ready that is already high when a flit is presented acknowledges it.
//
// PW must equal 4*DW.
// -----------------------------------------------------------------------------
module pcss_link_tx_sched #(
    parameter int DW        = 16,
    parameter int PW        = 64,
    parameter int TSW       = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tik,
    input  logic           cfg_valid,
    input  logic [PW-1:0]  cfg_data,
    output logic           cfg_ready,
    input  logic           spk_valid,
    input  logic [PW-1:0]  spk_data,
    input  logic [TSW-1:0] spk_ts,
    output logic           spk_ready,
    output logic [DW-1:0]  send_data_out,
    output logic           send_data_valid,
    output logic           send_data_par,
    input  logic           send_data_ready,
    input  logic           send_data_err,
    output logic [TSW-1:0] tik_cnt,
    output logic           busy,
    output logic           abort,
    output logic [7:0]     err_cnt,
    output logic [1:0]     dbg_state
);

    // Retry counter must be able to hold MAX_RETRY itself.
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] MAX_RTY = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_RELEASE = 2'd2
    } state_e;

    // Flit i of a packet, most significant flit first.
    function automatic logic [DW-1:0] flit_sel(input logic [PW-1:0] pkt,
                                               input logic [1:0]    i);
        logic [DW-1:0] f;
        case (i)
            2'd0:    f = pkt[PW-1   -: DW];
            2'd1:    f = pkt[3*DW-1 -: DW];
            2'd2:    f = pkt[2*DW-1 -: DW];
            default: f = pkt[DW-1:0];
        endcase
        return f;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e         state_q,    state_d;
    logic [PW-1:0]  pkt_q,      pkt_d;
    logic [1:0]     idx_q,      idx_d;
    logic [RW-1:0]  rty_q,      rty_d;
    logic           done_q,     done_d;
    logic           valid_q,    valid_d;
    logic [DW-1:0]  data_q,     data_d;
    logic           par_q,      par_d;
    logic           abort_q,    abort_d;
    logic           busy_q,     busy_d;
    logic [7:0]     err_cnt_q,  err_cnt_d;
    logic           tik_prev_q, tik_prev_d;
    logic [TSW-1:0] tik_cnt_q,  tik_cnt_d;

    // -------------------------------------------------------------------------
    // Request arbitration
    // -------------------------------------------------------------------------
    logic [TSW-1:0] ts_diff;
    logic           spk_elig;
    logic           idle;
    logic           take_cfg;
    logic           take_spk;

    // The spike is due or late when tik_cnt is at most half the counter range
    // ahead of spk_ts; anything further "ahead" is really a future step that
    // has wrapped, so it is held back.
    assign ts_diff  = tik_cnt_q - spk_ts;
    assign spk_elig = ~ts_diff[TSW-1];

    assign idle     = (state_q == S_IDLE);
    assign take_cfg = idle & cfg_valid;
    assign take_spk = idle & spk_valid & spk_elig & ~cfg_valid;

    // Readies are combinational, so they are also gated by rst_n to go low
    // the moment reset is applied rather than at the next edge.
    assign cfg_ready = rst_n & take_cfg;
    assign spk_ready = rst_n & take_spk;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        logic [PW-1:0] nxt_pkt;
        logic [DW-1:0] nxt_flit;

        state_d    = state_q;
        pkt_d      = pkt_q;
        idx_d      = idx_q;
        rty_d      = rty_q;
        done_d     = done_q;
        valid_d    = valid_q;
        data_d     = data_q;
        par_d      = par_q;
        abort_d    = 1'b0;
        err_cnt_d  = err_cnt_q;
        nxt_pkt    = take_cfg ? cfg_data : spk_data;
        nxt_flit   = flit_sel(pkt_q, idx_q);

        // Time step: a falling edge of tik seen between two samples advances
        // the counter regardless of what the link FSM is doing.
        tik_prev_d = tik;
        tik_cnt_d  = tik_cnt_q + TSW'(tik_prev_q & ~tik);

        case (state_q)
            S_IDLE: begin
                if (take_cfg || take_spk) begin
                    pkt_d   = nxt_pkt;
                    idx_d   = 2'd0;
                    rty_d   = '0;
                    done_d  = 1'b0;
                    state_d = S_DRIVE;
                    valid_d = 1'b1;
                    data_d  = flit_sel(nxt_pkt, 2'd0);
                    par_d   = ^flit_sel(nxt_pkt, 2'd0);
                end
            end

            S_DRIVE: begin
                // Flit and parity stay untouched until the receiver answers.
                if (send_data_ready) begin
                    valid_d = 1'b0;
                    state_d = S_RELEASE;
                    if (!send_data_err) begin
                        idx_d  = idx_q + 2'd1;
                        rty_d  = '0;
                        done_d = (idx_q == 2'd3);
                    end else begin
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        if (rty_q < MAX_RTY) begin
                            // Same idx is presented again after release.
                            rty_d = rty_q + RW'(1);
                        end else begin
                            abort_d = 1'b1;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            S_RELEASE: begin
                if (!send_data_ready) begin
                    if (done_q) begin
                        state_d = S_IDLE;
                        idx_d   = 2'd0;
                        rty_d   = '0;
                        done_d  = 1'b0;
                    end else begin
                        state_d = S_DRIVE;
                        valid_d = 1'b1;
                        data_d  = nxt_flit;
                        par_d   = ^nxt_flit;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pkt_q      <= '0;
            idx_q      <= 2'd0;
            rty_q      <= '0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            par_q      <= 1'b0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_cnt_q  <= 8'd0;
            tik_prev_q <= 1'b0;
            tik_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pkt_q      <= pkt_d;
            idx_q      <= idx_d;
            rty_q      <= rty_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            par_q      <= par_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
            err_cnt_q  <= err_cnt_d;
            tik_prev_q <= tik_prev_d;
            tik_cnt_q  <= tik_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign send_data_out   = data_q;
    assign send_data_valid = valid_q;
    assign send_data_par   = par_q;
    assign tik_cnt         = tik_cnt_q;
    assign busy            = busy_q;
    assign abort           = abort_q;
    assign err_cnt         = err_cnt_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_pcss_link_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_pcss_link_tx_sched
//
// Bench for pcss_link_tx_sched. A link receiver model acknowledges every flit
// within the cycle it is presented and can flag parity errors on a chosen flit
// value. Expected flits are queued when a request is driven and compared as
// the DUT puts them on the link.
// -----------------------------------------------------------------------------
module tb_pcss_link_tx_sched;
  localparam int DW  = 16;
  localparam int PW  = 64;
  localparam int TSW = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           tik = 1'b0;
  logic           cfg_valid = 1'b0;
  logic [PW-1:0]  cfg_data = '0;
  logic           cfg_ready;
  logic           spk_valid = 1'b0;
  logic [PW-1:0]  spk_data = '0;
  logic [TSW-1:0] spk_ts = '0;
  logic           spk_ready;
  logic [DW-1:0]  send_data_out;
  logic           send_data_valid;
  logic           send_data_par;
  logic           send_data_ready = 1'b0;
  logic           send_data_err = 1'b0;
  logic [TSW-1:0] tik_cnt;
  logic           busy;
  logic           abort;
  logic [7:0]     err_cnt;
  logic [1:0]     dbg_state;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pcss_link_tx_sched #(.DW(DW), .PW(PW), .TSW(TSW), .MAX_RETRY(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tik             (tik),
    .cfg_valid       (cfg_valid),
    .cfg_data        (cfg_data),
    .cfg_ready       (cfg_ready),
    .spk_valid       (spk_valid),
    .spk_data        (spk_data),
    .spk_ts          (spk_ts),
    .spk_ready       (spk_ready),
    .send_data_out   (send_data_out),
    .send_data_valid (send_data_valid),
    .send_data_par   (send_data_par),
    .send_data_ready (send_data_ready),
    .send_data_err   (send_data_err),
    .tik_cnt         (tik_cnt),
    .busy            (busy),
    .abort           (abort),
    .err_cnt         (err_cnt),
    .dbg_state       (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [DW-1:0] exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            exp_tik = 0;
  int            exp_err = 0;
  int            abort_seen = 0;
  int            err_left = 0;
  logic [DW-1:0] err_flit = '0;
  logic [DW-1:0] mon_exp;
  int unsigned   acc_cyc = 0;
  int unsigned   idle_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] flit_of(input logic [PW-1:0] p, input int i);
    logic [PW-1:0] s;
    s = p >> (DW * (3 - i));
    return s[DW-1:0];
  endfunction

  task automatic push_pkt(input logic [PW-1:0] p);
    for (int i = 0; i < 4; i++) exp_q.push_back(flit_of(p, i));
  endtask

  // ---------------------------------------------------------------------------
  // Link receiver + flit monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      send_data_ready = 1'b0;
      send_data_err   = 1'b0;
    end else begin
      if (abort) abort_seen++;
      if (send_data_valid) begin
        send_data_ready = 1'b1;
        if (err_left > 0 && send_data_out == err_flit) begin
          send_data_err = 1'b1;
          err_left--;
          if (exp_err != 255) exp_err++;
        end else begin
          send_data_err = 1'b0;
        end
        if (exp_q.size() == 0) begin
          check("flit_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_exp = exp_q.pop_front();
          check("flit_data", 64'(send_data_out), 64'(mon_exp));
          check("flit_par", 64'(send_data_par), 64'(^mon_exp));
        end
      end else begin
        send_data_ready = 1'b0;
        send_data_err   = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_req(input int port, input logic [PW-1:0] p, input logic [TSW-1:0] ts);
    @(negedge clk);
    if (port == 0) begin
      cfg_valid = 1'b1;
      cfg_data  = p;
    end else begin
      spk_valid = 1'b1;
      spk_data  = p;
      spk_ts    = ts;
    end
  endtask

  // Waits (bounded) for the request on 'port' to be taken, then drops valid.
  task automatic accept(input int port, input int budget, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (port == 0 ? cfg_ready : spk_ready) begin
        got = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (port == 0) cfg_valid = 1'b0;
    else spk_valid = 1'b0;
    check(tag, 64'(got), 64'd1);
  endtask

  task automatic send_pkt(input int port, input logic [PW-1:0] p, input logic [TSW-1:0] ts,
                          input int budget, input string tag);
    push_pkt(p);
    drive_req(port, p, ts);
    accept(port, budget, tag);
  endtask

  task automatic wait_idle(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    idle_cyc = cyc;
    check(tag, 64'(got), 64'd1);
  endtask

  task automatic tik_pulse();
    @(negedge clk); tik = 1'b1;
    @(negedge clk); tik = 1'b0;
    @(negedge clk);
    exp_tik = (exp_tik + 1) % 256;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [PW-1:0] p_cfg, p_spk;
    int unsigned   cfg_acc;

    // Reset with requests pending: nothing may be readied or driven.
    rst_n     = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = 64'hDEAD_BEEF_DEAD_BEEF;
    spk_valid = 1'b1;
    spk_ts    = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    check("rst_spk_ready", 64'(spk_ready), 64'd0);
    check("rst_valid", 64'(send_data_valid), 64'd0);
    check("rst_data", 64'(send_data_out), 64'd0);
    check("rst_par", 64'(send_data_par), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_abort", 64'(abort), 64'd0);
    check("rst_tik_cnt", 64'(tik_cnt), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    cfg_valid = 1'b0;
    spk_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic config packet: accept cycle plus 4 flits x 2 cycles.
    send_pkt(0, 64'h0123_4567_89AB_CDEF, '0, 5, "acc_cfg0");
    wait_idle("idle_cfg0");
    check("accept_to_idle", 64'(idle_cyc - acc_cyc + 1), 64'd9);
    check("q_empty_cfg0", 64'(exp_q.size()), 64'd0);

    // Spike due in the future is stalled until tik_cnt reaches it.
    tik_pulse();
    check("tik_cnt_1", 64'(tik_cnt), 64'(exp_tik));
    p_spk = {$urandom, $urandom};
    push_pkt(p_spk);
    drive_req(1, p_spk, 8'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("spk_stall_t1", 64'(spk_ready), 64'd0);
      @(negedge clk);
    end
    tik_pulse();
    #1;
    check("tik_cnt_2", 64'(tik_cnt), 64'(exp_tik));
    check("spk_stall_t2", 64'(spk_ready), 64'd0);
    check("busy_stall", 64'(busy), 64'd0);
    tik_pulse();
    check("tik_cnt_3", 64'(tik_cnt), 64'(exp_tik));
    accept(1, 1, "acc_spk_due");
    wait_idle("idle_spk_due");

    // Late spike (ts behind tik_cnt across the wrap) goes at once.
    send_pkt(1, {$urandom, $urandom}, 8'd255, 1, "acc_spk_late");
    wait_idle("idle_spk_late");

    // Config and eligible spike together: config first, spike on next IDLE.
    p_cfg = 64'hFEDC_BA98_7654_3210;
    p_spk = {$urandom, $urandom};
    push_pkt(p_cfg);
    push_pkt(p_spk);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_data = p_cfg;
    spk_valid = 1'b1; spk_data = p_spk; spk_ts = 8'd0;
    #1;
    check("dual_cfg_ready", 64'(cfg_ready), 64'd1);
    check("dual_spk_ready", 64'(spk_ready), 64'd0);
    accept(0, 1, "acc_dual_cfg");
    cfg_acc = acc_cyc;
    check("dual_busy_blocks_spk", 64'(spk_ready), 64'd0);
    accept(1, 30, "acc_dual_spk");
    check("dual_spk_gap", 64'(acc_cyc - cfg_acc), 64'd9);
    wait_idle("idle_dual");
    check("q_empty_dual", 64'(exp_q.size()), 64'd0);

    // One parity error on flit1: resent once, packet completes. A tik edge
    // lands in the middle of the transfer.
    p_cfg = 64'hA5A5_4567_0F0F_3C3C;
    err_flit = 16'h4567;
    err_left = 1;
    exp_q.push_back(flit_of(p_cfg, 0));
    exp_q.push_back(flit_of(p_cfg, 1));
    exp_q.push_back(flit_of(p_cfg, 1));
    exp_q.push_back(flit_of(p_cfg, 2));
    exp_q.push_back(flit_of(p_cfg, 3));
    drive_req(0, p_cfg, '0);
    accept(0, 5, "acc_err1");
    tik_pulse();
    check("tik_mid_xfer", 64'(tik_cnt), 64'(exp_tik));
    wait_idle("idle_err1");
    check("err_cnt_1", 64'(err_cnt), 64'(exp_err));
    check("err_injected_1", 64'(err_left), 64'd0);
    check("q_empty_err1", 64'(exp_q.size()), 64'd0);
    check("abort_none", 64'(abort_seen), 64'd0);

    // Reset while flit2 is on the link: output drops immediately.
    p_cfg = 64'h1111_2222_3333_4444;
    send_pkt(0, p_cfg, '0, 5, "acc_rst_pkt");
    begin
      bit got = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (send_data_valid && send_data_out == 16'h3333) begin
          got = 1'b1;
          break;
        end
      end
      check("saw_flit2", 64'(got), 64'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(send_data_valid), 64'd0);
    check("mid_rst_tik_cnt", 64'(tik_cnt), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
    exp_q.delete();
    exp_tik = 0;
    exp_err = 0;
    err_left = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_pkt(0, 64'h9ABC_DEF0_1234_5678, '0, 5, "acc_after_rst");
    wait_idle("idle_after_rst");
    check("q_empty_after_rst", 64'(exp_q.size()), 64'd0);

    // Four errors on flit1: three retries then abort; flits 2-3 never sent.
    p_cfg = 64'h1357_BEEF_2468_ACE0;
    err_flit = 16'hBEEF;
    err_left = 4;
    abort_seen = 0;
    exp_q.push_back(flit_of(p_cfg, 0));
    for (int i = 0; i < 4; i++) exp_q.push_back(flit_of(p_cfg, 1));
    drive_req(0, p_cfg, '0);
    accept(0, 5, "acc_abort");
    wait_idle("idle_abort");
    repeat (2) @(negedge clk);
    check("abort_pulses", 64'(abort_seen), 64'd1);
    check("err_cnt_4", 64'(err_cnt), 64'(exp_err));
    check("err_cnt_4_abs", 64'(err_cnt), 64'd4);
    check("q_empty_abort", 64'(exp_q.size()), 64'd0);

    // tik_cnt wrap 255 -> 0; spike with ts 0 becomes eligible at the wrap.
    for (int i = 0; i < 255; i++) tik_pulse();
    check("tik_cnt_255", 64'(tik_cnt), 64'd255);
    p_spk = {$urandom, $urandom};
    push_pkt(p_spk);
    drive_req(1, p_spk, 8'd0);
    #1;
    check("wrap_spk_stall", 64'(spk_ready), 64'd0);
    tik_pulse();
    check("tik_cnt_wrap", 64'(tik_cnt), 64'(exp_tik));
    accept(1, 1, "acc_spk_wrap");
    wait_idle("idle_wrap");
    check("q_empty_end", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
